// File: rtl/aes_keysched_ctrl.sv
`timescale 1ns/1ps
// aes_roundkey: combinational single-step AES key expansion.
// Produces round key RD from the previous one or two stored round keys.
// current_key = rk[RD-1]; prev_key = rk[RD-2] for AES-192/256 (for AES-192
// at RD==1 the upper half carries the key words w4,w5 that rk[0] lacks).
module aes_roundkey (
  input  logic [3:0]   rd,
  input  logic [1:0]   mode,
  input  logic [127:0] current_key,
  input  logic [127:0] prev_key,
  output logic [127:0] round_key
);
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] i);
    case (i)
      6'd1:    return 8'h01;
      6'd2:    return 8'h02;
      6'd3:    return 8'h04;
      6'd4:    return 8'h08;
      6'd5:    return 8'h10;
      6'd6:    return 8'h20;
      6'd7:    return 8'h40;
      6'd8:    return 8'h80;
      6'd9:    return 8'h1b;
      6'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] c0, c1, c2, c3, p0, p1, p2, p3;
  logic [31:0] t_in, t_src, t_out, o0, o1, o2, o3;
  logic [5:0]  widx, wmod, rc_idx;
  logic        rot;

  // one g-function per step; inputs are chosen so no word feeds back into it
  always_comb begin
    {c0, c1, c2, c3} = current_key;
    {p0, p1, p2, p3} = prev_key;
    widx   = {rd, 2'b00};
    wmod   = widx % 6'd6;
    t_in   = c3;
    rot    = 1'b1;
    rc_idx = {2'b00, rd};
    case (mode)
      MODE_192: begin
        // 4*rd mod 6 == 4 puts the g-word at position 2 of this round key
        if (rd == 4'd1)         t_in = p1;
        else if (wmod == 6'd4)  t_in = p3 ^ p2 ^ c3;
        rc_idx = (widx + 6'd2) / 6'd6;
      end
      MODE_256: begin
        rot    = ~rd[0];
        rc_idx = {3'b000, rd[3:1]};
      end
      default: ;
    endcase
    t_src = rot ? {t_in[23:0], t_in[31:24]} : t_in;
    t_out = sub_word(t_src) ^ {(rot ? rcon(rc_idx) : 8'h00), 24'h0};

    o0 = c0 ^ t_out;
    o1 = c1 ^ o0;
    o2 = c2 ^ o1;
    o3 = c3 ^ o2;
    case (mode)
      MODE_192: begin
        o0 = (wmod == 6'd0) ? (p2 ^ t_out) : (p2 ^ c3);
        o1 = p3 ^ o0;
        if (rd == 4'd1) begin
          o0 = p0;
          o1 = p1;
        end
        o2 = (wmod == 6'd4) ? (c0 ^ t_out) : (c0 ^ o1);
        o3 = c1 ^ o2;
      end
      MODE_256: begin
        o0 = p0 ^ t_out;
        o1 = p1 ^ o0;
        o2 = p2 ^ o1;
        o3 = p3 ^ o2;
      end
      default: ;
    endcase
    round_key = {o0, o1, o2, o3};
  end
endmodule

// aes_keysched_ctrl: iterative AES-128/192/256 key schedule, one round key
// per cycle, stored in a register file with a registered read port.
module aes_keysched_ctrl #(
  parameter int NUM_RK           = 15,
  parameter bit ZEROIZE_ON_FLUSH = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  input  logic         flush,
  output logic         busy,
  output logic         sched_valid,
  output logic         err,
  output logic [3:0]   num_rounds,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt, cnt_nxt, nr_q, idx1, idx2, rd_idx;
  logic [1:0]   mode_q;
  logic [63:0]  ext;
  logic [127:0] rk [NUM_RK];
  logic [127:0] cur_key, prev_key, round_key;
  logic         live_q, err_q, accept, load_ok, load_bad;

  assign in_ready    = live_q & (state != S_EXPAND);
  assign busy        = (state == S_EXPAND);
  assign sched_valid = (state == S_DONE);
  assign num_rounds  = (state == S_IDLE) ? 4'd0 : nr_q;
  assign err         = err_q;

  assign accept   = in_valid & in_ready & ~flush;
  assign load_bad = accept & (mode == MODE_BAD);
  assign load_ok  = accept & (mode != MODE_BAD);

  // state and round counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state: flush dominates, loads restart from IDLE or DONE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load_bad) begin
            state_nxt = S_IDLE;
          end else if (load_ok) begin
            state_nxt = S_EXPAND;
            cnt_nxt   = (mode == MODE_256) ? 4'd2 : 4'd1;
          end
        end
        S_EXPAND: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == nr_q) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // latched mode/Nr, ready-after-reset flag and illegal-mode pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_128;
      nr_q   <= '0;
      live_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      err_q  <= load_bad;
      if (load_ok) begin
        mode_q <= mode;
        nr_q   <= (mode == MODE_256) ? 4'd14 : (mode == MODE_192) ? 4'd12 : 4'd10;
      end
    end
  end

  // operand selection for the shared round-key step
  always_comb begin
    idx1     = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
    idx2     = (cnt >= 4'd2) ? cnt - 4'd2 : 4'd0;
    cur_key  = rk[idx1];
    prev_key = rk[idx2];
    if (mode_q == MODE_128)
      prev_key = cur_key;
    else if (mode_q == MODE_192 && cnt == 4'd1)
      prev_key = {ext, 64'h0};
  end

  aes_roundkey u_rk (
    .rd          (cnt),
    .mode        (mode_q),
    .current_key (cur_key),
    .prev_key    (prev_key),
    .round_key   (round_key)
  );

  // round-key storage: load writes rk[0] (and rk[1] for 256), EXPAND one per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (ZEROIZE_ON_FLUSH) begin
        for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
        ext <= '0;
      end
    end else if (flush) begin
      if (ZEROIZE_ON_FLUSH) begin
        for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
        ext <= '0;
      end
    end else if (load_ok) begin
      rk[0] <= key_in[255:128];
      if (mode == MODE_256) rk[1] <= key_in[127:0];
      ext <= key_in[127:64];
    end else if (state == S_EXPAND) begin
      rk[cnt] <= round_key;
    end
  end

  assign rd_idx = (rd_round <= nr_q) ? rd_round : 4'd0;

  // registered read: only a complete schedule within Nr is visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_key <= '0;
    else if (rd_en)
      rd_key <= (sched_valid && rd_round <= nr_q) ? rk[rd_idx] : 128'h0;
  end
endmodule

// File: tb/tb_aes_keysched_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for aes_keysched_ctrl with FIPS-197 key vectors.
module tb_aes_keysched_ctrl;
  logic         clk = 1'b0, rst_n = 1'b1;
  logic         in_valid = 1'b0, flush = 1'b0, rd_en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [255:0] key_in = '0;
  logic [3:0]   rd_round = '0;
  logic         in_ready, busy, sched_valid, err;
  logic [3:0]   num_rounds;
  logic [127:0] rd_key;

  int checks = 0, errors = 0;
  logic [127:0] exp_q[$];
  string        name_q[$];
  logic         rd_pend = 1'b0;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  always #5 clk = ~clk;

  aes_keysched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .key_in(key_in), .flush(flush), .busy(busy),
    .sched_valid(sched_valid), .err(err), .num_rounds(num_rounds),
    .rd_en(rd_en), .rd_round(rd_round), .rd_key(rd_key)
  );

  // a read sampled at an edge has its data presented after that edge
  always @(posedge clk) rd_pend <= rd_en;

  // monitor: pop the expected read data and compare
  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_key=%h with no expected entry", rd_key);
      end else begin
        logic [127:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rd_key !== e) begin
          errors++;
          $display("FAIL %s: rd_key=%h expected %h", n, rd_key, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic push_rd(input logic [3:0] r, input logic [127:0] e, input string n);
    rd_en    = 1'b1;
    rd_round = r;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic rd(input logic [3:0] r, input logic [127:0] e, input string n);
    push_rd(r, e, n);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic load(input logic [1:0] m, input logic [255:0] k);
    in_valid = 1'b1;
    mode     = m;
    key_in   = k;
    tick();
    in_valid = 1'b0;
  endtask

  // lat = edges still to go until DONE; checks the edge before and the edge of completion
  task automatic wait_done(input int lat, input logic [3:0] nr, input string n);
    repeat (lat - 1) tick();
    chk({n, "_busy_before"}, busy, 1);
    chk({n, "_sv_before"}, sched_valid, 0);
    tick();
    chk({n, "_sv_done"}, sched_valid, 1);
    chk({n, "_busy_done"}, busy, 0);
    chk({n, "_nr"}, num_rounds, nr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sv", sched_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_nr", num_rounds, 0);
    chk("rst_rd_key", rd_key, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // AES-128, with an ignored offer during EXPAND
    load(2'b00, K128);
    chk("a128_in_ready_expand", in_ready, 0);
    repeat (3) tick();
    in_valid = 1'b1; mode = 2'b00; key_in = KFIPS;
    tick();
    in_valid = 1'b0;
    wait_done(6, 4'd10, "a128");
    rd(4'd0,  128'h000102030405060708090a0b0c0d0e0f, "a128_rk0");
    rd(4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "a128_rk1");
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "a128_rk10");
    rd(4'd11, 128'h0, "a128_rk11_above_nr");

    // back-to-back AES-192 load from DONE; same-cycle read sees the old schedule
    push_rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "b2b_old_read");
    in_valid = 1'b1; mode = 2'b01; key_in = K192;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    chk("a192_sv_drop", sched_valid, 0);
    chk("a192_busy", busy, 1);
    wait_done(12, 4'd12, "a192");
    rd(4'd1,  128'h10111213141516175846f2f95c43f4fe, "a192_rk1");
    rd(4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, "a192_rk12");
    rd(4'd13, 128'h0, "a192_rk13_above_nr");

    // AES-256; read during EXPAND returns zero
    load(2'b10, K256);
    rd(4'd1, 128'h0, "a256_rd_during_expand");
    wait_done(12, 4'd14, "a256");
    rd(4'd1,  128'h101112131415161718191a1b1c1d1e1f, "a256_rk1");
    rd(4'd2,  128'ha573c29fa176c498a97fce93a572c09c, "a256_rk2");
    rd(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "a256_rk14");
    rd(4'd15, 128'h0, "a256_rk15_out_of_range");

    // flush from DONE
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done_sv", sched_valid, 0);
    chk("flush_done_nr", num_rounds, 0);
    chk("flush_done_in_ready", in_ready, 1);
    rd(4'd0, 128'h0, "flush_done_rk0");

    // illegal mode, then a normal AES-128 load
    load(2'b11, K128);
    chk("bad_err_pulse", err, 1);
    chk("bad_sv", sched_valid, 0);
    chk("bad_in_ready", in_ready, 1);
    chk("bad_nr", num_rounds, 0);
    tick();
    chk("bad_err_clear", err, 0);
    load(2'b00, K128);
    wait_done(10, 4'd10, "after_bad");
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "after_bad_rk10");

    // flush together with in_valid: key not accepted
    in_valid = 1'b1; mode = 2'b00; key_in = KFIPS; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_win_busy", busy, 0);
    chk("flush_win_sv", sched_valid, 0);
    tick();
    chk("flush_win_busy_later", busy, 0);

    // flush in EXPAND cycle 5 of AES-256, then immediate reload
    load(2'b10, K256);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_exp_busy", busy, 0);
    chk("flush_exp_sv", sched_valid, 0);
    chk("flush_exp_nr", num_rounds, 0);
    push_rd(4'd3, 128'h0, "flush_exp_rk3");
    in_valid = 1'b1; mode = 2'b00; key_in = KFIPS;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    wait_done(10, 4'd10, "fips");
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
    rd(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_rk0");

    // asynchronous reset mid-expansion
    load(2'b01, K192);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("amid_rst_in_ready", in_ready, 0);
    chk("amid_rst_busy", busy, 0);
    chk("amid_rst_sv", sched_valid, 0);
    chk("amid_rst_nr", num_rounds, 0);
    chk("amid_rst_rd_key", rd_key, 0);
    rst_n = 1'b1;
    tick();
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_sv", sched_valid, 0);
    rd(4'd0,  128'h0, "after_rst_rk0");
    rd(4'd12, 128'h0, "after_rst_rk12");

    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
